// File: rtl/fetch_arb_pkg.sv
// Shared definitions for the two-core instruction fetch arbiter:
// default widths, last-grant state encoding and the NOP returned on faults.
package fetch_arb_pkg;

    localparam int unsigned DEF_ADDR_W    = 32;
    localparam int unsigned DEF_DATA_W    = 32;
    localparam int unsigned DEF_ROM_DEPTH = 128;

    typedef logic [1:0] fetch_state_t;

    localparam fetch_state_t IDLE  = 2'd0;
    localparam fetch_state_t LAST0 = 2'd1;
    localparam fetch_state_t LAST1 = 2'd2;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    // Idle cycles keep the previous winner so priority survives gaps in traffic.
    function automatic fetch_state_t next_last(input logic [1:0] gnt, input fetch_state_t cur);
        fetch_state_t nxt;
        nxt = cur;
        if (gnt[0]) nxt = LAST0;
        if (gnt[1]) nxt = LAST1;
        return nxt;
    endfunction

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin grant selection; ties go to the core that did
// not win most recently, with core 0 favoured when there is no history.
module rr_arbiter_2
    import fetch_arb_pkg::*;
(
    input  logic [1:0]   req_i,
    input  fetch_state_t last_i,
    output logic [1:0]   gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_i == LAST0) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
    end

endmodule

// File: rtl/instr_fetch_arbiter.sv
// Arbitrates two cores onto one combinational instruction ROM and returns
// each fetched word one cycle later, substituting a NOP for illegal addresses.
module instr_fetch_arbiter
    import fetch_arb_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEF_ADDR_W,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ROM_DEPTH = DEF_ROM_DEPTH
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    output logic [ADDR_W-1:0] rom_A,
    input  logic [DATA_W-1:0] rom_RD,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              valid0,
    output logic              valid1,
    output logic              stall0,
    output logic              stall1,
    output logic              fault0,
    output logic              fault1
);

    fetch_state_t      state_q, state_d;
    logic [1:0]        req_gated;
    logic [1:0]        gnt;
    logic [ADDR_W-1:0] word_idx;
    logic              illegal;
    logic [DATA_W-1:0] fetch_word;

    logic [DATA_W-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
    logic              valid0_q, valid0_d, valid1_q, valid1_d;
    logic              fault0_q, fault0_d, fault1_q, fault1_d;

    // No grant may be issued while reset is held.
    assign req_gated = {req1, req0} & {2{~reset}};

    rr_arbiter_2 u_rr_arbiter_2 (
        .req_i  (req_gated),
        .last_i (state_q),
        .gnt_o  (gnt)
    );

    always_comb begin
        rom_A = '0;
        if (gnt[0]) rom_A = addr0;
        if (gnt[1]) rom_A = addr1;
    end

    assign word_idx   = rom_A >> 2;
    assign illegal    = (rom_A[1:0] != 2'b00) || (word_idx >= ADDR_W'(ROM_DEPTH));
    assign fetch_word = illegal ? DATA_W'(NOP_INSTR) : rom_RD;

    assign stall0 = req0 & ~gnt[0];
    assign stall1 = req1 & ~gnt[1];

    always_comb begin
        state_d  = next_last(gnt, state_q);
        valid0_d = gnt[0];
        valid1_d = gnt[1];
        fault0_d = gnt[0] & illegal;
        fault1_d = gnt[1] & illegal;
        rdata0_d = gnt[0] ? fetch_word : rdata0_q;
        rdata1_d = gnt[1] ? fetch_word : rdata1_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rdata0_q <= '0;
            rdata1_q <= '0;
            valid0_q <= 1'b0;
            valid1_q <= 1'b0;
            fault0_q <= 1'b0;
            fault1_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
            valid0_q <= valid0_d;
            valid1_q <= valid1_d;
            fault0_q <= fault0_d;
            fault1_q <= fault1_d;
        end
    end

    assign rdata0 = rdata0_q;
    assign rdata1 = rdata1_q;
    assign valid0 = valid0_q;
    assign valid1 = valid1_q;
    assign fault0 = fault0_q;
    assign fault1 = fault1_q;

endmodule

// File: tb/tb_instr_fetch_arbiter.sv
// Directed bench for instr_fetch_arbiter: a table of per-cycle vectors plus
// hand-written reset sequences, checked against a small ROM model.
module tb_instr_fetch_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [31:0] addr0, addr1;
    logic [31:0] rom_A, rom_RD;
    logic [31:0] rdata0, rdata1;
    logic        valid0, valid1, stall0, stall1, fault0, fault1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    instr_fetch_arbiter dut (
        .clk    (clk),
        .reset  (reset),
        .req0   (req0),
        .req1   (req1),
        .addr0  (addr0),
        .addr1  (addr1),
        .rom_A  (rom_A),
        .rom_RD (rom_RD),
        .rdata0 (rdata0),
        .rdata1 (rdata1),
        .valid0 (valid0),
        .valid1 (valid1),
        .stall0 (stall0),
        .stall1 (stall1),
        .fault0 (fault0),
        .fault1 (fault1)
    );

    // ROM image: word 0 is the boot word, word k is C0DE_0000|k; beyond the end reads garbage.
    function automatic logic [31:0] rom_word(input logic [31:0] idx);
        if (idx >= 32'd128) return 32'hDEAD_BEEF;
        if (idx == 32'd0)   return 32'h2002_0001;
        return 32'hC0DE_0000 | idx;
    endfunction

    always_comb rom_RD = rom_word(rom_A >> 2);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic        req0;
        logic        req1;
        logic [31:0] addr0;
        logic [31:0] addr1;
        logic        stall0;
        logic        stall1;
        logic [31:0] rom_a;
        logic        v0;
        logic        v1;
        logic        f0;
        logic        f1;
        logic [31:0] rd0;
        logic [31:0] rd1;
    } vec_t;

    vec_t vecs[20];

    initial begin
        //             r0    r1    addr0       addr1       s0    s1    rom_A       v0    v1    f0    f1    rdata0        rdata1
        vecs[0]  = '{1'b1, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b1, 1'b0, 1'b0, 1'b0, 32'h2002_0001, 32'h0};
        vecs[1]  = '{1'b0, 1'b1, 32'h0,     32'h202,   1'b0, 1'b0, 32'h202,   1'b0, 1'b1, 1'b0, 1'b1, 32'h2002_0001, 32'h0};
        vecs[2]  = '{1'b0, 1'b1, 32'h0,     32'h200,   1'b0, 1'b0, 32'h200,   1'b0, 1'b1, 1'b0, 1'b1, 32'h2002_0001, 32'h0};
        vecs[3]  = '{1'b0, 1'b1, 32'h0,     32'h6,     1'b0, 1'b0, 32'h6,     1'b0, 1'b1, 1'b0, 1'b1, 32'h2002_0001, 32'h0};
        vecs[4]  = '{1'b0, 1'b1, 32'h0,     32'h1FC,   1'b0, 1'b0, 32'h1FC,   1'b0, 1'b1, 1'b0, 1'b0, 32'h2002_0001, 32'hC0DE_007F};
        vecs[5]  = '{1'b1, 1'b1, 32'h4,     32'h8,     1'b0, 1'b1, 32'h4,     1'b1, 1'b0, 1'b0, 1'b0, 32'hC0DE_0001, 32'hC0DE_007F};
        vecs[6]  = '{1'b1, 1'b1, 32'h4,     32'h8,     1'b1, 1'b0, 32'h8,     1'b0, 1'b1, 1'b0, 1'b0, 32'hC0DE_0001, 32'hC0DE_0002};
        vecs[7]  = '{1'b1, 1'b1, 32'h4,     32'h8,     1'b0, 1'b1, 32'h4,     1'b1, 1'b0, 1'b0, 1'b0, 32'hC0DE_0001, 32'hC0DE_0002};
        vecs[8]  = '{1'b1, 1'b1, 32'h4,     32'h8,     1'b1, 1'b0, 32'h8,     1'b0, 1'b1, 1'b0, 1'b0, 32'hC0DE_0001, 32'hC0DE_0002};
        vecs[9]  = '{1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0001, 32'hC0DE_0002};
        vecs[10] = '{1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0001, 32'hC0DE_0002};
        vecs[11] = '{1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0001, 32'hC0DE_0002};
        vecs[12] = '{1'b1, 1'b1, 32'h10,    32'h14,    1'b0, 1'b1, 32'h10,    1'b1, 1'b0, 1'b0, 1'b0, 32'hC0DE_0004, 32'hC0DE_0002};
        vecs[13] = '{1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0004, 32'hC0DE_0002};
        vecs[14] = '{1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0004, 32'hC0DE_0002};
        vecs[15] = '{1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0004, 32'hC0DE_0002};
        vecs[16] = '{1'b1, 1'b1, 32'h10,    32'h14,    1'b1, 1'b0, 32'h14,    1'b0, 1'b1, 1'b0, 1'b0, 32'hC0DE_0004, 32'hC0DE_0005};
        vecs[17] = '{1'b1, 1'b1, 32'h20,    32'h14,    1'b0, 1'b1, 32'h20,    1'b1, 1'b0, 1'b0, 1'b0, 32'hC0DE_0008, 32'hC0DE_0005};
        vecs[18] = '{1'b0, 1'b0, 32'h0,     32'h0,     1'b0, 1'b0, 32'h0,     1'b0, 1'b0, 1'b0, 1'b0, 32'hC0DE_0008, 32'hC0DE_0005};
        vecs[19] = '{1'b1, 1'b0, 32'h3,     32'h0,     1'b0, 1'b0, 32'h3,     1'b1, 1'b0, 1'b1, 1'b0, 32'h0,         32'hC0DE_0005};

        reset = 1'b1;
        req0  = 1'b1;
        req1  = 1'b0;
        addr0 = 32'h0;
        addr1 = 32'h0;
        @(posedge clk);
        #1;
        check("rst_stall0", {31'b0, stall0}, 32'd1);
        check("rst_rom_a", rom_A, 32'h0);
        check("rst_valid", {30'b0, valid1, valid0}, 32'd0);
        check("rst_fault", {30'b0, fault1, fault0}, 32'd0);
        check("rst_rdata0", rdata0, 32'h0);
        check("rst_rdata1", rdata1, 32'h0);

        @(negedge clk);
        req0  = 1'b0;
        reset = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            req0  = vecs[i].req0;
            req1  = vecs[i].req1;
            addr0 = vecs[i].addr0;
            addr1 = vecs[i].addr1;
            #1;
            check($sformatf("v%0d_stall0", i), {31'b0, stall0}, {31'b0, vecs[i].stall0});
            check($sformatf("v%0d_stall1", i), {31'b0, stall1}, {31'b0, vecs[i].stall1});
            check($sformatf("v%0d_rom_a", i), rom_A, vecs[i].rom_a);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid0", i), {31'b0, valid0}, {31'b0, vecs[i].v0});
            check($sformatf("v%0d_valid1", i), {31'b0, valid1}, {31'b0, vecs[i].v1});
            check($sformatf("v%0d_fault0", i), {31'b0, fault0}, {31'b0, vecs[i].f0});
            check($sformatf("v%0d_fault1", i), {31'b0, fault1}, {31'b0, vecs[i].f1});
            check($sformatf("v%0d_rdata0", i), rdata0, vecs[i].rd0);
            check($sformatf("v%0d_rdata1", i), rdata1, vecs[i].rd1);
        end

        // Reset lands in the same cycle core 0 is being granted.
        @(negedge clk);
        req0  = 1'b1;
        req1  = 1'b0;
        addr0 = 32'h0;
        #1;
        check("mid_pre_stall0", {31'b0, stall0}, 32'd0);
        reset = 1'b1;
        #1;
        check("mid_stall0", {31'b0, stall0}, 32'd1);
        check("mid_rom_a", rom_A, 32'h0);
        check("mid_rdata1_clr", rdata1, 32'h0);
        @(posedge clk);
        #1;
        check("mid_valid0", {31'b0, valid0}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        req0  = 1'b0;
        @(posedge clk);
        #1;
        check("rel_valid", {30'b0, valid1, valid0}, 32'd0);

        // Priority history was cleared by reset, so core 0 wins this tie.
        @(negedge clk);
        req0  = 1'b1;
        req1  = 1'b1;
        addr0 = 32'h4;
        addr1 = 32'hC;
        #1;
        check("rel_tie_rom_a", rom_A, 32'h4);
        check("rel_tie_stall1", {31'b0, stall1}, 32'd1);
        @(posedge clk);
        #1;
        check("rel_tie_valid0", {31'b0, valid0}, 32'd1);
        check("rel_tie_rdata0", rdata0, 32'hC0DE_0001);

        @(negedge clk);
        req0 = 1'b0;
        #1;
        check("rel_r1_stall1", {31'b0, stall1}, 32'd0);
        @(posedge clk);
        #1;
        check("rel_r1_valid1", {31'b0, valid1}, 32'd1);
        check("rel_r1_rdata1", rdata1, 32'hC0DE_0003);
        check("rel_r1_fault1", {31'b0, fault1}, 32'd0);

        @(negedge clk);
        req1 = 1'b0;
        @(posedge clk);
        #1;
        check("tail_valid1", {31'b0, valid1}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/instr_fetch_arbiter.md
INSTR_FETCH_ARBITER -- requirements
Module: instr_fetch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, byte-address width of fetch requests and ROM address.
REQ-002 Parameter DATA_W, default 32, instruction word width.
REQ-003 Parameter ROM_DEPTH, default 128, number of words in the shared instruction ROM.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 req0 / req1  in  1  fetch request from core 0 / core 1.
REQ-007 addr0 / addr1  in  ADDR_W  byte fetch address (PC) of core 0 / core 1.
REQ-008 rom_A  out  ADDR_W  byte address driven to the shared combinational ROM.
REQ-009 rom_RD  in  DATA_W  combinational ROM read data for rom_A.
REQ-010 rdata0 / rdata1  out  DATA_W  registered instruction returned to core 0 / core 1.
REQ-011 valid0 / valid1  out  1  one-cycle pulse: rdataN holds the word fetched the previous cycle.
REQ-012 stall0 / stall1  out  1  combinational: coreN requested but was not granted this cycle.
REQ-013 fault0 / fault1  out  1  one-cycle pulse alongside validN when the fetch address was illegal.

Function
REQ-014 The block SHALL grant at most one requester per cycle, and SHALL grant none when req0=req1=0.
REQ-015 A single active requester SHALL be granted in the same cycle.
REQ-016 When both cores request, the block SHALL grant the core not granted most recently; after reset, core 0 wins the first tie.
REQ-017 FSM states: IDLE (no prior grant), LAST0, LAST1; grant to core N moves to LASTN; a cycle with no grant SHALL hold the current state (priority is not reset by idle cycles).
REQ-018 rom_A SHALL equal the granted core's address combinationally; with no grant rom_A SHALL be 0.
REQ-019 stallN SHALL equal reqN AND NOT grantN in the same cycle; coreN holds addrN stable while stalled (the arbiter does not latch addresses).
REQ-020 On the edge following a grant to core N, rdataN SHALL capture rom_RD and validN SHALL be 1 for exactly one cycle (fixed latency 1).
REQ-021 rdataN SHALL hold its last value when not granted; the non-granted core's valid SHALL be 0.
REQ-022 A fetch is illegal if addr[1:0] != 0 or (addr >> 2) >= ROM_DEPTH; the response SHALL then be rdataN = 32'h0000_0000 (NOP) with validN=1 and faultN=1.
REQ-023 Back-to-back requests from both cores SHALL alternate grants every cycle (0,1,0,1,...), giving each 50% throughput with no starvation.
REQ-024 A deasserted request while stalled SHALL be dropped with no response.

Reset
REQ-025 On reset assertion, SHALL asynchronously set state=IDLE, valid0=valid1=0, fault0=fault1=0, rdata0=rdata1=0.
REQ-026 Reset asserted mid-fetch SHALL discard the pending response; no validN pulse SHALL follow reset release without a new grant.
REQ-027 While reset is high, no grant SHALL be issued; rom_A=0 and stall0/stall1 equal req0/req1.

Structure
REQ-028 Package fetch_arb_pkg SHALL hold the FSM state enum (IDLE, LAST0, LAST1), ADDR_W, DATA_W, ROM_DEPTH defaults and the NOP_INSTR constant.
REQ-029 Grant selection SHALL be a sub-module rr_arbiter_2 (two requests, last-grant state in, one-hot grant out); the top holds address mux, range check and response registers.

Verification
REQ-030 Reset then req0=1, addr0=0x0, rom word0=0x2002_0001 -> stall0=0, next cycle valid0=1, rdata0=0x2002_0001, fault0=0.
REQ-031 req0=req1=1 held 4 cycles, addr0=0x4, addr1=0x8 -> grants 0,1,0,1; valid0/valid1 alternate from cycle 2; stall toggles opposite grant.
REQ-032 req1=1 addr1=0x202 (misaligned) -> next cycle valid1=1, fault1=1, rdata1=0x0000_0000; then addr1=0x200 (word 128) -> fault1=1 again.
REQ-033 Grant core 1, idle 3 cycles, then req0=req1=1 -> core 0 granted first (priority held across idle).
REQ-034 Assert reset in the cycle core 0 is granted -> valid0 never pulses; after release, req1=1 alone -> core 1 served with latency 1.
